// File: rtl/geo_seq_gen_if.sv
// Bundle of the request and output-stream signals for geo_seq_gen.
//
// Signals:
//   start, seed, base, length, sat_mode : sequence request, sampled in IDLE
//   out_ready                           : consumer accepts the current term
//   out_valid, out_data, out_last       : term stream towards the consumer
//   busy, done, ovf                     : generator status
//
// Modports:
//   master : the requester/consumer side (drives requests and out_ready)
//   slave  : the generator side (drives the term stream and status)
interface geo_seq_gen_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [DATA_W-1:0] seed;
  logic [DATA_W-1:0] base;
  logic [CNT_W-1:0]  length;
  logic              sat_mode;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              ovf;

  modport master (
    output start, seed, base, length, sat_mode, out_ready,
    input  out_valid, out_data, out_last, busy, done, ovf
  );

  modport slave (
    input  start, seed, base, length, sat_mode, out_ready,
    output out_valid, out_data, out_last, busy, done, ovf
  );
endinterface

// File: rtl/geo_seq_gen.sv
// Geometric sequence generator: emits length terms seed, seed*base,
// seed*base^2, ... on a valid/ready stream, wrapping or saturating on
// overflow, with a sticky overflow flag.
//
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   bus       : geo_seq_gen_if.slave (request, term stream, status)
//   fsm_state : current FSM state (0 = IDLE, 1 = RUN) for observation
//
// Handshake: a term transfers on every rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_data, out_last and out_valid hold their values. out_valid never
// depends combinationally on out_ready.
module geo_seq_gen #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  geo_seq_gen_if.slave  bus,
  output logic          fsm_state
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [DATA_W-1:0]   term;
  logic [DATA_W-1:0]   base_q;
  logic [CNT_W-1:0]    len_q;
  logic [CNT_W-1:0]    cnt;
  logic                sat_q;
  logic                ovf_q;
  logic                done_q;

  logic [2*DATA_W-1:0] prod;
  logic                hi_nz;
  logic [DATA_W-1:0]   term_nxt;
  logic                last_term;
  logic                accept;
  logic                xfer;
  logic                done_nxt;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    xfer      = 1'b0;
    done_nxt  = 1'b0;

    // Counter only ever reaches len_q-1 in RUN, and len_q is nonzero there.
    last_term = (state == RUN) && (cnt == len_q - CNT_W'(1));

    // Full-width product; the upper half tells us whether the term overflowed.
    prod     = {{DATA_W{1'b0}}, term} * {{DATA_W{1'b0}}, base_q};
    hi_nz    = |prod[2*DATA_W-1:DATA_W];
    term_nxt = (sat_q && hi_nz) ? {DATA_W{1'b1}} : prod[DATA_W-1:0];

    case (state)
      IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          if (bus.length != '0) state_nxt = RUN;
          else                  done_nxt  = 1'b1;  // empty sequence completes at once
        end
      end
      RUN: begin
        if (bus.out_ready) begin
          xfer = 1'b1;
          if (last_term) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      term   <= '0;
      base_q <= '0;
      len_q  <= '0;
      cnt    <= '0;
      sat_q  <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
      if (accept) begin
        term   <= bus.seed;
        base_q <= bus.base;
        len_q  <= bus.length;
        sat_q  <= bus.sat_mode;
        cnt    <= '0;
        ovf_q  <= 1'b0;
      end else if (xfer && !last_term) begin
        // The final term is never multiplied, so it cannot raise ovf.
        term <= term_nxt;
        cnt  <= cnt + CNT_W'(1);
        if (hi_nz) ovf_q <= 1'b1;
      end
    end
  end

  assign bus.out_valid = (state == RUN);
  assign bus.out_data  = term;
  assign bus.out_last  = last_term;
  assign bus.busy      = (state == RUN);
  assign bus.done      = done_q;
  assign bus.ovf       = ovf_q;
  assign fsm_state     = state;

endmodule

// File: tb/tb_geo_seq_gen.sv
// Bench for geo_seq_gen: a 32-bit and an 8-bit instance receive the same
// requests and run in lockstep; each has its own expected-term queue.
module tb_geo_seq_gen;

  logic clk = 1'b0;
  logic rst;
  logic st32;
  logic st8;

  always #5 clk = ~clk;

  geo_seq_gen_if #(.DATA_W(32), .CNT_W(8)) bus32 ();
  geo_seq_gen_if #(.DATA_W(8),  .CNT_W(8)) bus8 ();

  geo_seq_gen #(.DATA_W(32), .CNT_W(8)) dut32 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus32),
    .fsm_state (st32)
  );

  geo_seq_gen #(.DATA_W(8), .CNT_W(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus8),
    .fsm_state (st8)
  );

  typedef struct {
    logic [31:0] seed;
    logic [31:0] base;
    logic [7:0]  length;
    logic        sat;
    int          stall_idx;
    int          stall_cyc;
    int          glitch_idx;
    int          rst_after;
    logic [31:0] exp_last32;
    logic        exp_ovf32;
    logic [7:0]  exp_last8;
    logic        exp_ovf8;
  } vec_t;

  logic [31:0] exp_q32[$];
  logic        exp_o32[$];
  logic [7:0]  exp_q8[$];
  logic        exp_o8[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference step: returns {upper-half-nonzero, next term} for width w.
  function automatic logic [32:0] model_step(input logic [31:0] t, input logic [31:0] b,
                                             input logic sat, input int w);
    logic [63:0] p;
    logic [63:0] mask;
    logic        hi;
    logic [31:0] r;
    p    = {32'd0, t} * {32'd0, b};
    mask = (64'd1 << w) - 64'd1;
    hi   = (p >> w) != 64'd0;
    r    = (sat && hi) ? mask[31:0] : (p[31:0] & mask[31:0]);
    return {hi, r};
  endfunction

  task automatic set_start(input logic s, input logic [31:0] seed, input logic [31:0] base,
                           input logic [7:0] len, input logic sat);
    bus32.start = s;  bus32.seed = seed;      bus32.base = base;      bus32.length = len; bus32.sat_mode = sat;
    bus8.start  = s;  bus8.seed  = seed[7:0]; bus8.base  = base[7:0]; bus8.length  = len; bus8.sat_mode  = sat;
  endtask

  task automatic set_ready(input logic r);
    bus32.out_ready = r;
    bus8.out_ready  = r;
  endtask

  // Caller is positioned at a negedge. Runs one request to completion.
  // When b2b is set, returns at the done cycle so the next start lands on it.
  task automatic run_vec(input vec_t v, input bit b2b);
    logic [31:0] t32;
    logic [31:0] t8;
    logic [32:0] r;
    logic        ov32;
    logic        ov8;
    logic [31:0] last32;
    logic [7:0]  last8;
    logic        was_last;
    bit          last_seen;
    bit          glitched;
    int          stall_left;
    int          idx;
    int          guard;

    t32 = v.seed;
    t8  = v.seed & 32'hFF;
    for (int i = 0; i < int'(v.length); i++) begin
      exp_q32.push_back(t32);
      exp_q8.push_back(t8[7:0]);
      r = model_step(t32, v.base, v.sat, 32);
      exp_o32.push_back((i < int'(v.length) - 1) && r[32]);
      t32 = r[31:0];
      r = model_step(t8, v.base & 32'hFF, v.sat, 8);
      exp_o8.push_back((i < int'(v.length) - 1) && r[32]);
      t8 = r[31:0];
    end

    set_start(1'b1, v.seed, v.base, v.length, v.sat);
    set_ready(1'b1);
    @(negedge clk);
    set_start(1'b0, v.seed, v.base, v.length, v.sat);

    if (v.length == 8'd0) begin
      chk("zero_len_valid32", bus32.out_valid, 1'b0);
      chk("zero_len_valid8",  bus8.out_valid,  1'b0);
      chk("zero_len_done32",  bus32.done,      1'b1);
      chk("zero_len_done8",   bus8.done,       1'b1);
      @(negedge clk);
      chk("zero_len_done_drop32", bus32.done,      1'b0);
      chk("zero_len_valid_after", bus32.out_valid, 1'b0);
      return;
    end

    ov32 = 1'b0; ov8 = 1'b0;
    idx = 0; guard = 0; last_seen = 0; glitched = 0;
    stall_left = v.stall_cyc;
    last32 = '0; last8 = '0;

    while (!last_seen && guard < 300) begin
      guard++;
      set_start(1'b0, v.seed, v.base, v.length, v.sat);

      if (idx == v.rst_after) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid32", bus32.out_valid, 1'b0);
        chk("rst_valid8",  bus8.out_valid,  1'b0);
        chk("rst_last32",  bus32.out_last,  1'b0);
        chk("rst_busy32",  bus32.busy,      1'b0);
        chk("rst_done32",  bus32.done,      1'b0);
        chk("rst_ovf8",    bus8.ovf,        1'b0);
        chk("rst_data32",  bus32.out_data,  32'd0);
        chk("rst_data8",   bus8.out_data,   8'd0);
        chk("rst_state32", st32,            1'b0);
        @(negedge clk);
        chk("rst_no_done32", bus32.done,      1'b0);
        chk("rst_no_done8",  bus8.done,       1'b0);
        chk("rst_idle_val",  bus32.out_valid, 1'b0);
        exp_q32.delete(); exp_o32.delete(); exp_q8.delete(); exp_o8.delete();
        return;
      end

      chk("valid32", bus32.out_valid, 1'b1);
      chk("valid8",  bus8.out_valid,  1'b1);
      chk("busy32",  bus32.busy,      1'b1);
      chk("state32", st32,            1'b1);
      chk("done_low32", bus32.done,   1'b0);
      chk("data32",  bus32.out_data,  exp_q32[0]);
      chk("data8",   bus8.out_data,   exp_q8[0]);
      chk("last32",  bus32.out_last,  exp_q32.size() == 1);
      chk("last8",   bus8.out_last,   exp_q8.size() == 1);
      chk("ovf32",   bus32.ovf,       ov32);
      chk("ovf8",    bus8.ovf,        ov8);

      if (idx == v.stall_idx && stall_left > 0) begin
        set_ready(1'b0);
        stall_left--;
      end else begin
        set_ready(1'b1);
      end

      if (idx == v.glitch_idx && !glitched) begin
        set_start(1'b1, ~v.seed, v.base + 32'd5, 8'd2, ~v.sat);
        glitched = 1;
      end

      if (bus32.out_ready) begin
        last32   = bus32.out_data;
        last8    = bus8.out_data;
        was_last = (exp_q32.size() == 1);
        void'(exp_q32.pop_front());
        void'(exp_q8.pop_front());
        ov32 = ov32 | exp_o32.pop_front();
        ov8  = ov8  | exp_o8.pop_front();
        idx++;
        if (was_last) last_seen = 1;
      end
      @(negedge clk);
    end

    set_start(1'b0, v.seed, v.base, v.length, v.sat);
    set_ready(1'b1);
    if (!last_seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: sequence not completed after %0d cycles, required completion", guard);
      exp_q32.delete(); exp_o32.delete(); exp_q8.delete(); exp_o8.delete();
      return;
    end

    chk("end_data32", last32, v.exp_last32);
    chk("end_data8",  last8,  v.exp_last8);
    chk("done32",     bus32.done,      1'b1);
    chk("done8",      bus8.done,       1'b1);
    chk("idle_valid32", bus32.out_valid, 1'b0);
    chk("idle_valid8",  bus8.out_valid,  1'b0);
    chk("idle_busy32",  bus32.busy,      1'b0);
    chk("end_ovf32",  bus32.ovf,       v.exp_ovf32);
    chk("end_ovf8",   bus8.ovf,        v.exp_ovf8);

    if (!b2b) begin
      @(negedge clk);
      chk("done_pulse32", bus32.done, 1'b0);
      chk("done_pulse8",  bus8.done,  1'b0);
    end
  endtask

  vec_t vecs[13];

  initial begin
    //             seed          base          len  sat stall  cyc glitch rst   last32        ov32  last8  ov8
    vecs[0]  = '{32'd1,       32'd3,       8'd5, 0,  -1,  0,  -1,  -1, 32'd81,       0, 8'd81,  0};
    vecs[1]  = '{32'd1,       32'd3,       8'd5, 0,   2,  3,  -1,  -1, 32'd81,       0, 8'd81,  0};
    vecs[2]  = '{32'd1,       32'd3,       8'd7, 0,  -1,  0,  -1,  -1, 32'd729,      0, 8'd217, 1};
    vecs[3]  = '{32'd1,       32'd3,       8'd7, 1,  -1,  0,  -1,  -1, 32'd729,      0, 8'd255, 1};
    vecs[4]  = '{32'd1,       32'd3,       8'd6, 0,  -1,  0,  -1,  -1, 32'd243,      0, 8'd243, 0};
    vecs[5]  = '{32'd7,       32'd0,       8'd4, 0,  -1,  0,   1,  -1, 32'd0,        0, 8'd0,   0};
    vecs[6]  = '{32'd5,       32'd1,       8'd3, 0,   1,  2,  -1,  -1, 32'd5,        0, 8'd5,   0};
    vecs[7]  = '{32'd200,     32'd2,       8'd3, 1,  -1,  0,  -1,  -1, 32'd800,      0, 8'd255, 1};
    vecs[8]  = '{32'h10000,   32'h10000,   8'd3, 0,  -1,  0,  -1,  -1, 32'd0,        1, 8'd0,   0};
    vecs[9]  = '{32'h10000,   32'h10000,   8'd3, 1,  -1,  0,   0,  -1, 32'hFFFFFFFF, 1, 8'd0,   0};
    vecs[10] = '{32'd9,       32'd2,       8'd0, 0,  -1,  0,  -1,  -1, 32'd0,        0, 8'd0,   0};
    vecs[11] = '{32'd1,       32'd3,       8'd5, 0,  -1,  0,  -1,   2, 32'd0,        0, 8'd0,   0};
    vecs[12] = '{32'd1,       32'd3,       8'd5, 0,  -1,  0,  -1,  -1, 32'd81,       0, 8'd81,  0};

    rst = 1'b1;
    set_start(1'b1, 32'hDEAD_BEEF, 32'd7, 8'd4, 1'b0);
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    chk("reset_valid32", bus32.out_valid, 1'b0);
    chk("reset_valid8",  bus8.out_valid,  1'b0);
    chk("reset_busy32",  bus32.busy,      1'b0);
    chk("reset_done32",  bus32.done,      1'b0);
    chk("reset_ovf32",   bus32.ovf,       1'b0);
    chk("reset_last32",  bus32.out_last,  1'b0);
    chk("reset_data32",  bus32.out_data,  32'd0);
    chk("reset_state32", st32,            1'b0);
    chk("reset_state8",  st8,             1'b0);
    set_start(1'b0, 32'd0, 32'd0, 8'd0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", bus32.out_valid, 1'b0);

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], (i == 1) || (i == 6));
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/geo_seq_gen.md
GEO_SEQ_GEN -- requirements
Module: geo_seq_gen

Interface
REQ-001 Parameter DATA_W, default 32, width of the seed, the base and each sequence term.
REQ-002 Parameter CNT_W, default 8, width of the sequence-length field and the term counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a new sequence; sampled only in IDLE.
REQ-006 seed  input  DATA_W  first term; latched on accepted start.
REQ-007 base  input  DATA_W  multiplier; latched on accepted start.
REQ-008 length  input  CNT_W  number of terms to emit; latched on accepted start.
REQ-009 sat_mode  input  1  1 = saturate on overflow, 0 = wrap modulo 2^DATA_W; latched on accepted start.
REQ-010 out_ready  input  1  downstream accepts the current term.
REQ-011 out_valid  output  1  out_data holds a valid term.
REQ-012 out_data  output  DATA_W  current sequence term.
REQ-013 out_last  output  1  the current term is the final term of the sequence.
REQ-014 busy  output  1  high in RUN.
REQ-015 done  output  1  one-cycle pulse when a sequence completes.
REQ-016 ovf  output  1  sticky overflow flag; cleared on the next accepted start or on rst.

Function
REQ-017 FSM states are IDLE and RUN; after reset the FSM is in IDLE.
REQ-018 Start acceptance: start=1 in IDLE latches seed, base, length and sat_mode, clears ovf and the counter, and moves the FSM to RUN when length!=0.
REQ-019 Zero length: start with length==0 stays in IDLE, emits no term, and pulses done on the next cycle.
REQ-020 Start while in RUN is ignored and changes no state.
REQ-021 Latency: out_valid rises the cycle after an accepted start, with out_data=seed.
REQ-022 Transfer: a term transfers on any cycle with out_valid && out_ready.
REQ-023 Backpressure: while out_valid && !out_ready, out_data, out_last and out_valid hold stable.
REQ-024 Term update: on a non-last transfer, term <= f(term*base), computed as a full 2*DATA_W-bit product, and the counter increments.
REQ-025 Overflow, wrap mode (sat_mode=0): f keeps the low DATA_W bits of the product.
REQ-026 Overflow, saturate mode (sat_mode=1): f yields all-ones when the upper DATA_W bits are nonzero, otherwise the low bits; all-ones times any base >=1 stays all-ones.
REQ-027 ovf sets the cycle after a non-last transfer whose product upper half is nonzero, in either mode.
REQ-028 No product is evaluated on the last transfer, so ovf never sets from it.
REQ-029 out_last = out_valid && (counter == length-1).
REQ-030 Completion: the transfer with out_last=1 moves the FSM to IDLE, drops out_valid the next cycle and pulses done for that one cycle.
REQ-031 Back-to-back: start may be accepted in the same cycle that done is high.
REQ-032 base==0: the second and later terms are 0, with no ovf; base==1 repeats seed.
REQ-033 Counter width: length up to 2^CNT_W-1 is supported; the counter never wraps within a sequence.

Reset
REQ-034 rst=1 at a clock edge forces IDLE, out_valid=0, out_last=0, busy=0, done=0, ovf=0, out_data=0 and counter=0, overriding all other inputs.
REQ-035 rst mid-sequence abandons the sequence without a done pulse.
REQ-036 After rst falls, the first start is accepted normally.

Verification
REQ-037 DATA_W=32, seed=1, base=3, length=5, out_ready=1 -> out_data 1,3,9,27,81 on consecutive cycles; out_last with 81; done the cycle after; ovf=0.
REQ-038 Same as REQ-037 with out_ready low for 3 cycles while term 9 is presented -> 9 holds stable for 4 cycles; sequence, out_last and done otherwise identical.
REQ-039 DATA_W=8, seed=1, base=3, length=7, sat_mode=0 -> 1,3,9,27,81,243,217; ovf rises the cycle after 243 transfers.
REQ-040 Same as REQ-039 with sat_mode=1 -> 1,3,9,27,81,243,255.
REQ-041 Overflow on the last term: DATA_W=8, seed=1, base=3, length=6 -> sequence ends at 243; ovf stays 0.
REQ-042 Boundary cases:
- length=0 -> no out_valid and one done pulse.
- start pulsed mid-RUN -> ignored.
- rst after the 2nd term of a length-5 run -> all outputs 0 the next cycle and no done.
- a fresh start then gives seed first.
